// File: rtl/bitwise_logic_pkg.sv
// Shared types and the per-bit operator for bitwise_logic_unit.
package bitwise_logic_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    // Single-bit result of the selected logic operation.
    function automatic logic blu_bit(input op_e op, input logic a, input logic b);
        logic r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/blu_cov_monitor.sv
// Output toggle coverage: sticky seen0/seen1 per bit, saturating handshake
// counter and the stuck-bit flag. A clear beats a same-cycle handshake.
module blu_cov_monitor #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STUCK_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hs,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] seen0,
    output logic [WIDTH-1:0] seen1,
    output logic             stuck_flag
);

    localparam int unsigned CNT_W = $clog2(STUCK_THRESH + 1);

    logic [CNT_W-1:0] cnt;

    // Accumulate observed bit values and count handshakes up to the threshold.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            seen0 <= '0;
            seen1 <= '0;
            cnt   <= '0;
        end else if (hs) begin
            seen0 <= seen0 | ~data;
            seen1 <= seen1 | data;
            if (cnt != CNT_W'(STUCK_THRESH)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Flag once enough beats were seen and some bit has not taken both values.
    always_comb begin
        stuck_flag = (cnt == CNT_W'(STUCK_THRESH)) && ((seen0 & seen1) != '1);
    end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined N-bit AND/OR/XOR/NAND unit with valid/ready on both sides and
// output toggle coverage. Optional macro BLU_FAULT_INJECT_EN adds
// fault_mask/fault_val ports that overlay the output after the last stage.
module bitwise_logic_unit
    import bitwise_logic_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned STUCK_THRESH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             clear_cov,
    output logic [WIDTH-1:0] seen0,
    output logic [WIDTH-1:0] seen1,
    output logic             stuck_flag
`ifdef BLU_FAULT_INJECT_EN
    ,
    input  logic [WIDTH-1:0] fault_mask,
    input  logic [WIDTH-1:0] fault_val
`endif
);

    localparam int unsigned LAST = LATENCY - 1;

    logic [WIDTH-1:0]                result;
    logic [LATENCY-1:0]              stage_valid;
    logic [LATENCY-1:0][WIDTH-1:0]   stage_data;
    logic [LATENCY:0]                chain_valid;
    logic [LATENCY:0][WIDTH-1:0]     chain_data;
    logic [LATENCY-1:0]              load;
    logic                            tail_full;
    logic [WIDTH-1:0]                last_data;
    logic                            out_hs;

    // Operator applied bit by bit in front of stage 0.
    always_comb begin
        result = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            result[i] = blu_bit(op_e'(op), a[i], b[i]);
        end
    end

    // Source of each stage: the input beat for stage 0, the previous stage otherwise.
    assign chain_valid = {stage_valid, in_valid};
    assign chain_data  = {stage_data, result};

    // A stage loads if any stage from it to the end is empty, or the output drains.
    always_comb begin
        load      = '0;
        tail_full = 1'b1;
        for (int k = int'(LATENCY) - 1; k >= 0; k--) begin
            tail_full = tail_full & stage_valid[k];
            load[k]   = out_ready | ~tail_full;
        end
    end

    // Pipeline stages; data only updates on a valid source to keep idle output quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
            stage_data  <= '0;
        end else begin
            for (int k = 0; k < int'(LATENCY); k++) begin
                if (load[k]) begin
                    stage_valid[k] <= chain_valid[k];
                    if (chain_valid[k]) begin
                        stage_data[k] <= chain_data[k];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = stage_valid[LAST];
    assign last_data = stage_data[LAST];

`ifdef BLU_FAULT_INJECT_EN
    assign out = (last_data & ~fault_mask) | (fault_val & fault_mask);
`else
    assign out = last_data;
`endif

    assign out_hs = out_valid && out_ready;

    blu_cov_monitor #(
        .WIDTH        (WIDTH),
        .STUCK_THRESH (STUCK_THRESH)
    ) u_cov (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_cov),
        .hs         (out_hs),
        .data       (out),
        .seen0      (seen0),
        .seen1      (seen1),
        .stuck_flag (stuck_flag)
    );

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed self-checking bench for bitwise_logic_unit (WIDTH=8, LATENCY=2, STUCK_THRESH=16).
module tb_bitwise_logic_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       clear_cov;
    logic [7:0] seen0, seen1;
    logic       stuck_flag;
    logic [7:0] fm, fv;

    int total = 0;
    int bad   = 0;

    logic [7:0] va [32];
    logic [7:0] vb [32];

    always #5 clk = ~clk;

    bitwise_logic_unit #(
        .WIDTH(8), .LATENCY(2), .STUCK_THRESH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .clear_cov  (clear_cov),
        .seen0      (seen0),
        .seen1      (seen1),
        .stuck_flag (stuck_flag)
`ifdef BLU_FAULT_INJECT_EN
        ,
        .fault_mask (fm),
        .fault_val  (fv)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference result including the fault overlay the bench drives.
    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        case (o)
            2'd0:    r = x & y;
            2'd1:    r = x | y;
            2'd2:    r = x ^ y;
            default: r = ~(x & y);
        endcase
`ifdef BLU_FAULT_INJECT_EN
        r = (r & ~fm) | (fv & fm);
`endif
        return r;
    endfunction

    task automatic clear_coverage();
        @(negedge clk);
        clear_cov = 1'b1;
        @(negedge clk);
        clear_cov = 1'b0;
    endtask

    // Stream n beats from va/vb with out_ready high and check each result in order.
    task automatic run(input int n, input logic [1:0] o, input int pre_chk);
        int ptr = 0;
        int rcv = 0;
        bit done_pre = 1'b0;
        out_ready = 1'b1;
        op = o;
        for (int cyc = 0; cyc < 200 && rcv < n; cyc++) begin
            @(negedge clk);
            in_valid = (ptr < n);
            a = (ptr < n) ? va[ptr] : 8'h00;
            b = (ptr < n) ? vb[ptr] : 8'h00;
            #1;
            if (pre_chk >= 0 && rcv == pre_chk && !done_pre) begin
                check("pre_thresh_stuck", 32'(stuck_flag), 'h0);
                done_pre = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("run_res", 32'(out), 32'(model(o, va[rcv], vb[rcv])));
                rcv++;
            end
            if (in_valid && in_ready) ptr++;
        end
        check("run_count", 32'(rcv), 32'(n));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] eo [4];
        logic [7:0] bv [5];
        int ptr;
        int rcv;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        out_ready = 1'b1; clear_cov = 1'b0; fm = '0; fv = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 'h0);
        check("rst_out", 32'(out), 'h0);
        check("rst_seen0", 32'(seen0), 'h0);
        check("rst_seen1", 32'(seen1), 'h0);
        check("rst_stuck", 32'(stuck_flag), 'h0);
        check("rst_in_ready", 32'(in_ready), 'h1);

        repeat (20) @(negedge clk);
        #1;
        check("idle_stuck", 32'(stuck_flag), 'h0);
        check("idle_valid", 32'(out_valid), 'h0);

        // Four ops back to back on the same operands.
        eo[0] = 8'hC0; eo[1] = 8'hFC; eo[2] = 8'h3C; eo[3] = 8'h3F;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 4) begin
                in_valid = 1'b1; a = 8'hF0; b = 8'hCC; op = 2'(k);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k >= 2 && k < 6) begin
                check("ops_valid", 32'(out_valid), 'h1);
                check("ops_out", 32'(out), 32'(eo[k-2]));
            end
            if (k == 6) check("ops_drained", 32'(out_valid), 'h0);
        end
        check("ops_seen0", 32'(seen0), 'hFF);
        check("ops_seen1", 32'(seen1), 'hFF);

        clear_coverage();
        #1;
        check("clr_seen1", 32'(seen1), 'h0);

        // Backpressure: 5 cycles of out_ready low while feeding, then release.
        bv[0] = 8'h11; bv[1] = 8'h22; bv[2] = 8'h33; bv[3] = 8'h44; bv[4] = 8'h55;
        ptr = 0; rcv = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (ptr < 5);
            a  = (ptr < 5) ? bv[ptr] : 8'h00;
            b  = 8'h00;
            op = 2'd2;
            #1;
            if (cyc < 2) begin
                check("bp_rdy_open", 32'(in_ready), 'h1);
            end else if (cyc < 5) begin
                check("bp_rdy_full", 32'(in_ready), 'h0);
                check("bp_hold_valid", 32'(out_valid), 'h1);
                check("bp_hold_out", 32'(out), 'h11);
            end
            if (out_valid && out_ready) begin
                if (rcv < 5) check("bp_order", 32'(out), 32'(bv[rcv]));
                else         check("bp_extra", 32'(out_valid), 'h0);
                rcv++;
            end
            if (in_valid && in_ready) ptr++;
        end
        check("bp_count", 32'(rcv), 'h5);
        in_valid = 1'b0;

        // AND with b=0: bit 1 never seen.
        clear_coverage();
        for (int i = 0; i < 16; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'h00;
        end
        run(16, 2'd0, 15);
        check("stk_seen1", 32'(seen1), 'h0);
        check("stk_seen0", 32'(seen0), 'hFF);
        check("stk_flag", 32'(stuck_flag), 'h1);

        // Full toggle: one 0x00 then 16 of 0xFF.
        clear_coverage();
        va[0] = 8'h00; vb[0] = 8'h00;
        for (int i = 1; i < 17; i++) begin
            va[i] = 8'hFF;
            vb[i] = 8'hFF;
        end
        run(17, 2'd0, -1);
        check("tog_seen0", 32'(seen0), 'hFF);
        check("tog_seen1", 32'(seen1), 'hFF);
        check("tog_flag", 32'(stuck_flag), 'h0);

`ifdef BLU_FAULT_INJECT_EN
        // Stuck-at-0 overlay on every bit.
        clear_coverage();
        fm = 8'hFF; fv = 8'h00;
        for (int i = 0; i < 16; i++) begin
            va[i] = 8'(i * 37);
            vb[i] = 8'(~(i * 11));
        end
        run(16, 2'd0, 15);
        check("flt_seen1", 32'(seen1), 'h0);
        check("flt_flag", 32'(stuck_flag), 'h1);
        fm = 8'h00;
`endif

        // Reset with a full pipeline discards beats and clears coverage.
        clear_coverage();
        va[0] = 8'h0F; vb[0] = 8'hFF;
        run(1, 2'd0, -1);
        check("pre_rst_seen1", 32'(seen1), 'h0F);
        check("pre_rst_seen0", 32'(seen0), 'hF0);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'h77; b = 8'h00; op = 2'd2;
        end
        #1;
        check("fill_rdy", 32'(in_ready), 'h0);
        check("fill_valid", 32'(out_valid), 'h1);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 'h0);
        check("mid_rst_out", 32'(out), 'h0);
        check("mid_rst_seen0", 32'(seen0), 'h0);
        check("mid_rst_seen1", 32'(seen1), 'h0);
        check("mid_rst_rdy", 32'(in_ready), 'h1);

        // clear_cov on the handshake cycle wins.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; a = 8'h5A; b = 8'h00; op = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("chs_valid", 32'(out_valid), 'h1);
        check("chs_out", 32'(out), 'h5A);
        @(negedge clk);
        out_ready = 1'b1; clear_cov = 1'b1;
        @(negedge clk);
        clear_cov = 1'b0;
        #1;
        check("chs_seen0", 32'(seen0), 'h0);
        check("chs_seen1", 32'(seen1), 'h0);
        check("chs_consumed", 32'(out_valid), 'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
